// File: rtl/ram_port_arbiter_pkg.sv
// Shared arbiter state encodings and requester ids.
package ram_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } arb_state_e;

  localparam logic REQ_CPU    = 1'b0;
  localparam logic REQ_LOADER = 1'b1;

  localparam int unsigned WAIT_W = 8;

endpackage

// File: rtl/arb_grant_2.sv
// Two-way grant decision: ownership, then round-robin or fixed priority with forced loader grant.
module arb_grant_2
  import ram_port_arbiter_pkg::*;
#(
  parameter int unsigned FIXED_PRIORITY = 0
) (
  input  logic       valid0,
  input  logic       valid1,
  input  arb_state_e state,
  input  logic       last_grant,
  input  logic       force1,
  output logic       grant0,
  output logic       grant1
);

  // At most one grant; an owner excludes the other requester entirely.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    case (state)
      ARB_OWN0: grant0 = valid0;
      ARB_OWN1: grant1 = valid1;
      default: begin
        if (valid0 && valid1) begin
          if (FIXED_PRIORITY != 0) begin
            grant1 = force1;
          end else begin
            grant1 = (last_grant == REQ_CPU);
          end
          grant0 = !grant1;
        end else begin
          grant0 = valid0;
          grant1 = valid1;
        end
      end
    endcase
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares the single-port main RAM between the core (requester 0) and the loader (requester 1).
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned ADDR_WIDTH     = 13,
  parameter int unsigned READ_LATENCY   = 1,
  parameter int unsigned FIXED_PRIORITY = 0,
  parameter int unsigned MAX_WAIT       = 15
) (
  input  logic                  clock,
  input  logic                  active_low_reset,
  input  logic                  req0_valid,
  input  logic                  req0_write,
  input  logic                  req0_lock,
  input  logic [ADDR_WIDTH-1:0] req0_address,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic                  req1_write,
  input  logic                  req1_lock,
  input  logic [ADDR_WIDTH-1:0] req1_address,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  req1_ready,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,
  output logic                  ram_enable,
  output logic                  ram_write_enable,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  localparam int unsigned LAST = READ_LATENCY - 1;

  arb_state_e              state;
  arb_state_e              state_next;
  logic                    last_grant;
  logic [WAIT_W-1:0]       wait_count;
  logic [READ_LATENCY-1:0] pipe_valid;
  logic [READ_LATENCY-1:0] pipe_id;
  logic [DATA_WIDTH-1:0]   rdata0_q;
  logic [DATA_WIDTH-1:0]   rdata1_q;
  logic                    grant0;
  logic                    grant1;
  logic                    force1;
  logic                    xfer0;
  logic                    xfer1;
  logic                    rd_issue;

  assign force1   = (FIXED_PRIORITY != 0) && (wait_count == WAIT_W'(MAX_WAIT));
  assign xfer0    = req0_valid && req0_ready;
  assign xfer1    = req1_valid && req1_ready;
  assign rd_issue = ram_enable && !ram_write_enable;

  arb_grant_2 #(
    .FIXED_PRIORITY(FIXED_PRIORITY)
  ) u_grant (
    .valid0    (req0_valid),
    .valid1    (req1_valid),
    .state     (state),
    .last_grant(last_grant),
    .force1    (force1),
    .grant0    (grant0),
    .grant1    (grant1)
  );

  // Ownership state register.
  always_ff @(posedge clock or negedge active_low_reset) begin
    if (!active_low_reset) state <= ARB_IDLE;
    else                   state <= state_next;
  end

  // Lock-driven ownership transitions.
  always_comb begin
    state_next = state;
    case (state)
      ARB_IDLE: begin
        if (xfer0 && req0_lock)      state_next = ARB_OWN0;
        else if (xfer1 && req1_lock) state_next = ARB_OWN1;
      end
      ARB_OWN0: if ((xfer0 || !req0_valid) && !req0_lock) state_next = ARB_IDLE;
      ARB_OWN1: if ((xfer1 || !req1_valid) && !req1_lock) state_next = ARB_IDLE;
      default:  state_next = ARB_IDLE;
    endcase
  end

  // Ready strobes and RAM mux of the granted requester; quiet while in reset.
  always_comb begin
    req0_ready       = 1'b0;
    req1_ready       = 1'b0;
    ram_enable       = 1'b0;
    ram_write_enable = 1'b0;
    ram_address      = '0;
    ram_wdata        = '0;
    if (active_low_reset) begin
      req0_ready = grant0;
      req1_ready = grant1;
    end
    if (req1_ready) begin
      ram_enable       = 1'b1;
      ram_write_enable = req1_write;
      ram_address      = req1_address;
      ram_wdata        = req1_wdata;
    end else if (req0_ready) begin
      ram_enable       = 1'b1;
      ram_write_enable = req0_write;
      ram_address      = req0_address;
      ram_wdata        = req0_wdata;
    end
  end

  // Round-robin history, updated only when something transfers.
  always_ff @(posedge clock or negedge active_low_reset) begin
    if (!active_low_reset)  last_grant <= REQ_LOADER;
    else if (xfer0)         last_grant <= REQ_CPU;
    else if (xfer1)         last_grant <= REQ_LOADER;
  end

  // Loader starvation counter; saturates so the forced grant holds until served.
  always_ff @(posedge clock or negedge active_low_reset) begin
    if (!active_low_reset) begin
      wait_count <= '0;
    end else if ((FIXED_PRIORITY == 0) || !req1_valid || xfer1) begin
      wait_count <= '0;
    end else if (wait_count != WAIT_W'(MAX_WAIT)) begin
      wait_count <= wait_count + WAIT_W'(1);
    end
  end

  // Read tag pipeline matching the RAM latency.
  always_ff @(posedge clock or negedge active_low_reset) begin
    if (!active_low_reset) begin
      pipe_valid <= '0;
      pipe_id    <= '0;
    end else begin
      pipe_valid[0] <= rd_issue;
      pipe_id[0]    <= req1_ready;
      for (int i = 1; i < int'(READ_LATENCY); i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_id[i]    <= pipe_id[i-1];
      end
    end
  end

  assign rsp0_valid = pipe_valid[LAST] && (pipe_id[LAST] == REQ_CPU);
  assign rsp1_valid = pipe_valid[LAST] && (pipe_id[LAST] == REQ_LOADER);
  assign rsp0_rdata = rsp0_valid ? ram_rdata : rdata0_q;
  assign rsp1_rdata = rsp1_valid ? ram_rdata : rdata1_q;

  // Hold last returned word per requester between pulses.
  always_ff @(posedge clock or negedge active_low_reset) begin
    if (!active_low_reset) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      if (rsp0_valid) rdata0_q <= ram_rdata;
      if (rsp1_valid) rdata1_q <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench: round-robin/latency-1 instance and fixed-priority/latency-2 instance share stimulus.
module tb_ram_port_arbiter;

  logic        clock = 1'b0;
  logic        active_low_reset = 1'b0;
  logic        req0_valid = 1'b0, req0_write = 1'b0, req0_lock = 1'b0;
  logic [12:0] req0_address = '0;
  logic [15:0] req0_wdata = '0;
  logic        req1_valid = 1'b0, req1_write = 1'b0, req1_lock = 1'b0;
  logic [12:0] req1_address = '0;
  logic [15:0] req1_wdata = '0;

  logic        rr_req0_ready, rr_req1_ready, rr_rsp0_valid, rr_rsp1_valid;
  logic [15:0] rr_rsp0_rdata, rr_rsp1_rdata, rr_ram_wdata, rr_ram_rdata;
  logic        rr_ram_enable, rr_ram_write_enable;
  logic [12:0] rr_ram_address;
  logic        fp_req0_ready, fp_req1_ready, fp_rsp0_valid, fp_rsp1_valid;
  logic [15:0] fp_rsp0_rdata, fp_rsp1_rdata, fp_ram_wdata, fp_ram_rdata;
  logic        fp_ram_enable, fp_ram_write_enable;
  logic [12:0] fp_ram_address;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  ram_port_arbiter #(.READ_LATENCY(1), .FIXED_PRIORITY(0)) dut_rr (
    .clock(clock), .active_low_reset(active_low_reset),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_lock(req0_lock),
    .req0_address(req0_address), .req0_wdata(req0_wdata), .req0_ready(rr_req0_ready),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_lock(req1_lock),
    .req1_address(req1_address), .req1_wdata(req1_wdata), .req1_ready(rr_req1_ready),
    .rsp0_valid(rr_rsp0_valid), .rsp0_rdata(rr_rsp0_rdata),
    .rsp1_valid(rr_rsp1_valid), .rsp1_rdata(rr_rsp1_rdata),
    .ram_enable(rr_ram_enable), .ram_write_enable(rr_ram_write_enable),
    .ram_address(rr_ram_address), .ram_wdata(rr_ram_wdata), .ram_rdata(rr_ram_rdata)
  );

  ram_port_arbiter #(.READ_LATENCY(2), .FIXED_PRIORITY(1), .MAX_WAIT(3)) dut_fp (
    .clock(clock), .active_low_reset(active_low_reset),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_lock(req0_lock),
    .req0_address(req0_address), .req0_wdata(req0_wdata), .req0_ready(fp_req0_ready),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_lock(req1_lock),
    .req1_address(req1_address), .req1_wdata(req1_wdata), .req1_ready(fp_req1_ready),
    .rsp0_valid(fp_rsp0_valid), .rsp0_rdata(fp_rsp0_rdata),
    .rsp1_valid(fp_rsp1_valid), .rsp1_rdata(fp_rsp1_rdata),
    .ram_enable(fp_ram_enable), .ram_write_enable(fp_ram_write_enable),
    .ram_address(fp_ram_address), .ram_wdata(fp_ram_wdata), .ram_rdata(fp_ram_rdata)
  );

  // RAM models: latency 1 and latency 2.
  logic [15:0] rr_mem [0:8191];
  logic [15:0] fp_mem [0:8191];
  logic [15:0] rr_rd, fp_rd1, fp_rd2;

  always @(posedge clock) begin
    if (rr_ram_enable) begin
      if (rr_ram_write_enable) rr_mem[rr_ram_address] <= rr_ram_wdata;
      else                     rr_rd <= rr_mem[rr_ram_address];
    end
  end
  assign rr_ram_rdata = rr_rd;

  always @(posedge clock) begin
    if (fp_ram_enable) begin
      if (fp_ram_write_enable) fp_mem[fp_ram_address] <= fp_ram_wdata;
      else                     fp_rd1 <= fp_mem[fp_ram_address];
    end
    fp_rd2 <= fp_rd1;
  end
  assign fp_ram_rdata = fp_rd2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set0(input logic v, input logic w, input logic l, input logic [12:0] a, input logic [15:0] d);
    req0_valid = v; req0_write = w; req0_lock = l; req0_address = a; req0_wdata = d;
  endtask

  task automatic set1(input logic v, input logic w, input logic l, input logic [12:0] a, input logic [15:0] d);
    req1_valid = v; req1_write = w; req1_lock = l; req1_address = a; req1_wdata = d;
  endtask

  task automatic idle(input int n);
    set0(0, 0, 0, '0, '0);
    set1(0, 0, 0, '0, '0);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    // Reset: outputs quiet even with a request pending.
    step();
    set0(1, 0, 0, 13'h010, '0);
    #1;
    check("rst_req0_ready", 32'(rr_req0_ready), 0);
    check("rst_ram_enable", 32'(rr_ram_enable), 0);
    check("rst_ram_address", 32'(rr_ram_address), 0);
    check("rst_rsp0_rdata", 32'(rr_rsp0_rdata), 0);
    set0(0, 0, 0, '0, '0);
    step();
    active_low_reset = 1'b1;
    step();

    // Preload by writes; first tie goes to requester 0.
    set0(1, 1, 0, 13'h010, 16'h1111);
    set1(1, 1, 0, 13'h020, 16'h2222);
    #1;
    check("pre_req0_ready", 32'(rr_req0_ready), 1);
    check("pre_req1_ready", 32'(rr_req1_ready), 0);
    check("pre_we", 32'(rr_ram_write_enable), 1);
    check("pre_addr", 32'(rr_ram_address), 32'h010);
    step();
    set0(0, 0, 0, '0, '0);
    #1;
    check("pre_req1_ready", 32'(rr_req1_ready), 1);
    check("pre_wdata", 32'(rr_ram_wdata), 32'h2222);
    step();

    // Round-robin reads, both valid.
    set0(1, 0, 0, 13'h010, '0);
    set1(1, 0, 0, 13'h020, '0);
    #1;
    check("rr_c1_req0_ready", 32'(rr_req0_ready), 1);
    check("rr_c1_req1_ready", 32'(rr_req1_ready), 0);
    step();
    set0(0, 0, 0, '0, '0);
    #1;
    check("rr_c2_req1_ready", 32'(rr_req1_ready), 1);
    check("rr_c2_rsp0_valid", 32'(rr_rsp0_valid), 1);
    check("rr_c2_rsp0_rdata", 32'(rr_rsp0_rdata), 32'h1111);
    step();
    set1(0, 0, 0, '0, '0);
    #1;
    check("rr_c3_rsp1_valid", 32'(rr_rsp1_valid), 1);
    check("rr_c3_rsp1_rdata", 32'(rr_rsp1_rdata), 32'h2222);
    check("rr_c3_rsp0_valid", 32'(rr_rsp0_valid), 0);
    check("rr_c3_rsp0_hold", 32'(rr_rsp0_rdata), 32'h1111);
    step();

    // Write then read-after-write next cycle.
    set1(1, 1, 0, 13'h005, 16'hBEEF);
    #1;
    check("raw_req1_ready", 32'(rr_req1_ready), 1);
    step();
    set1(0, 0, 0, '0, '0);
    set0(1, 0, 0, 13'h005, '0);
    #1;
    check("raw_req0_ready", 32'(rr_req0_ready), 1);
    step();
    set0(0, 0, 0, '0, '0);
    #1;
    check("raw_rsp0_valid", 32'(rr_rsp0_valid), 1);
    check("raw_rsp0_rdata", 32'(rr_rsp0_rdata), 32'hBEEF);
    step();

    // Loader read so requester 0 wins the next tie.
    set1(1, 0, 0, 13'h020, '0);
    step();
    set1(0, 0, 0, '0, '0);
    #1;
    check("pre4_rsp1_rdata", 32'(rr_rsp1_rdata), 32'h2222);
    step();

    // Lock: requester 0 owns across a 2-cycle valid gap.
    set0(1, 0, 1, 13'h010, '0);
    set1(1, 0, 0, 13'h020, '0);
    #1;
    check("lk_c1_req0_ready", 32'(rr_req0_ready), 1);
    check("lk_c1_req1_ready", 32'(rr_req1_ready), 0);
    step();
    set0(0, 0, 1, '0, '0);
    #1;
    check("lk_c2_req1_ready", 32'(rr_req1_ready), 0);
    check("lk_c2_ram_enable", 32'(rr_ram_enable), 0);
    step();
    #1;
    check("lk_c3_req1_ready", 32'(rr_req1_ready), 0);
    step();
    set0(1, 0, 1, 13'h005, '0);
    #1;
    check("lk_c4_req0_ready", 32'(rr_req0_ready), 1);
    check("lk_c4_req1_ready", 32'(rr_req1_ready), 0);
    step();
    set0(1, 0, 0, 13'h020, '0);
    #1;
    check("lk_c5_req0_ready", 32'(rr_req0_ready), 1);
    check("lk_c5_req1_ready", 32'(rr_req1_ready), 0);
    check("lk_c5_rsp0_rdata", 32'(rr_rsp0_rdata), 32'hBEEF);
    step();
    set0(0, 0, 0, '0, '0);
    #1;
    check("lk_c6_req1_ready", 32'(rr_req1_ready), 1);
    check("lk_c6_ram_address", 32'(rr_ram_address), 32'h020);
    step();
    idle(2);

    // Requester 0 cancels while requester 1 owns.
    set1(1, 1, 1, 13'h030, 16'h3333);
    #1;
    check("own1_c1_req1_ready", 32'(rr_req1_ready), 1);
    step();
    set1(0, 0, 1, '0, '0);
    set0(1, 0, 0, 13'h010, '0);
    #1;
    check("own1_c2_req0_ready", 32'(rr_req0_ready), 0);
    check("own1_c2_ram_enable", 32'(rr_ram_enable), 0);
    step();
    set0(0, 0, 0, '0, '0);
    set1(1, 0, 0, 13'h030, '0);
    #1;
    check("own1_c3_ram_enable", 32'(rr_ram_enable), 1);
    check("own1_c3_ram_address", 32'(rr_ram_address), 32'h030);
    check("own1_c3_req0_ready", 32'(rr_req0_ready), 0);
    step();
    set1(0, 0, 0, '0, '0);
    #1;
    check("own1_c4_ram_enable", 32'(rr_ram_enable), 0);
    check("own1_c4_rsp1_rdata", 32'(rr_rsp1_rdata), 32'h3333);
    check("own1_c4_rsp0_valid", 32'(rr_rsp0_valid), 0);
    idle(3);

    // Fixed priority with forced loader grant after 3 waits; latency 2.
    set0(1, 0, 0, 13'h010, '0);
    set1(1, 0, 0, 13'h020, '0);
    #1;
    check("fp_c1_req0_ready", 32'(fp_req0_ready), 1);
    check("fp_c1_req1_ready", 32'(fp_req1_ready), 0);
    step();
    #1;
    check("fp_c2_req1_ready", 32'(fp_req1_ready), 0);
    check("fp_c2_rsp0_valid", 32'(fp_rsp0_valid), 0);
    step();
    #1;
    check("fp_c3_req1_ready", 32'(fp_req1_ready), 0);
    check("fp_c3_rsp0_valid", 32'(fp_rsp0_valid), 1);
    check("fp_c3_rsp0_rdata", 32'(fp_rsp0_rdata), 32'h1111);
    step();
    #1;
    check("fp_c4_req1_ready", 32'(fp_req1_ready), 1);
    check("fp_c4_req0_ready", 32'(fp_req0_ready), 0);
    step();
    #1;
    check("fp_c5_wait_count", 32'(dut_fp.wait_count), 0);
    check("fp_c5_req0_ready", 32'(fp_req0_ready), 1);
    check("fp_c5_req1_ready", 32'(fp_req1_ready), 0);
    step();
    set0(0, 0, 0, '0, '0);
    set1(0, 0, 0, '0, '0);
    #1;
    check("fp_c6_rsp1_valid", 32'(fp_rsp1_valid), 1);
    check("fp_c6_rsp1_rdata", 32'(fp_rsp1_rdata), 32'h2222);
    idle(4);

    // Reset while a latency-2 read is in flight.
    set0(1, 0, 0, 13'h005, '0);
    #1;
    check("rd_rst_req0_ready", 32'(fp_req0_ready), 1);
    step();
    set0(0, 0, 0, '0, '0);
    active_low_reset = 1'b0;
    #1;
    check("rd_rst_ram_enable", 32'(fp_ram_enable), 0);
    check("rd_rst_rsp0_valid", 32'(fp_rsp0_valid), 0);
    step();
    step();
    active_low_reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("post_rst_fp_rsp0", 32'(fp_rsp0_valid), 0);
      check("post_rst_rr_rsp0", 32'(rr_rsp0_valid), 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
Shares the single-port, synchronous-read main RAM between two requesters: the j2 core data port (requester 0) and a boot/debug loader (requester 1). It accepts valid/ready requests, decides which requester is served each cycle, and issues one RAM access per cycle. It returns read data tagged to the issuing requester after the fixed RAM latency. It sits between j2 memory_* signals, the loader and memory_ram, replacing the direct core-to-RAM wiring.

Parameters:
DATA_WIDTH, `WIDTH (16), data word width
ADDR_WIDTH, 13, RAM word address width
READ_LATENCY, 1, RAM read latency in cycles; legal 1 or 2
FIXED_PRIORITY, 0, 0 = round-robin; 1 = requester 0 wins ties
MAX_WAIT, 15, fixed-priority mode only: cycles requester 1 may wait before a forced grant; legal 1..255

Ports:
clock  in  1  system clock, all logic on posedge
active_low_reset  in  1  asynchronous, active-low reset
req0_valid / req1_valid  in  1  request present
req0_write / req1_write  in  1  1 = write, 0 = read
req0_lock / req1_lock  in  1  keep ownership after this transfer
req0_address / req1_address  in  ADDR_WIDTH  word address
req0_wdata / req1_wdata  in  DATA_WIDTH  write data
req0_ready / req1_ready  out  1  request accepted this cycle (combinational)
rsp0_valid / rsp1_valid  out  1  read data valid, one-cycle pulse
rsp0_rdata / rsp1_rdata  out  DATA_WIDTH  read data
ram_enable  out  1  RAM access this cycle
ram_write_enable  out  1  RAM write strobe
ram_address  out  ADDR_WIDTH  RAM address
ram_wdata  out  DATA_WIDTH  RAM write data
ram_rdata  in  DATA_WIDTH  RAM read data, READ_LATENCY after ram_enable

Behaviour:
- Reset (async assert, sync deassert): state=IDLE, last_grant=1 so requester 0 wins the first tie, wait_count=0, response pipeline cleared. All outputs are 0 during and after reset until the first request.
- Transfer happens when reqN_valid & reqN_ready. A requester holds valid, write, address, wdata and lock stable until ready. Dropping valid before ready is legal and cancels the request.
- At most one ready per cycle. ram_enable = req0_ready | req1_ready. The RAM signals are a combinational mux of the granted requester.
- FSM states:
  - IDLE: grant by mode.
  - OWN0: only requester 0 may be granted.
  - OWN1: only requester 1 may be granted.
- FSM transitions:
  - IDLE->OWNn on a transfer with reqn_lock=1.
  - OWNn->IDLE on a transfer with lock=0, or when valid=0 and lock=0.
  - OWNn holds while lock=1, even with valid=0.
- Round-robin, IDLE only: a single valid requester is granted. If both are valid, the one not in last_grant wins. last_grant updates only on a transfer.
- Fixed priority, IDLE only:
  - Requester 0 wins ties.
  - wait_count increments each cycle req1_valid is high and not granted. It saturates at MAX_WAIT and clears on a requester-1 transfer or when req1_valid=0.
  - When wait_count==MAX_WAIT, requester 1 is granted over requester 0.
- Lock does not override the forced grant from IDLE. Once in OWNn, the other requester waits regardless.
- Reads:
  - Requester id is shifted through a READ_LATENCY-deep valid/id pipeline.
  - rspN_valid is high exactly READ_LATENCY cycles after the accepting edge, with rspN_rdata = ram_rdata. rspN_rdata is held between pulses.
  - Writes produce no response.
- Back-to-back: one transfer per cycle sustained. A read after a write to the same address in the next cycle returns the new data.
- Reset mid-read: in-flight responses are discarded and no rsp pulse follows deassertion.
- Both requests target the same address in one cycle: only the granted one is issued; the other is served later with current RAM contents.

Decomposition:
- common.h gains `ARB_IDLE/`ARB_OWN0/`ARB_OWN1 state encodings and `REQ_CPU=0/`REQ_LOADER=1 ids.
- One sub-module, arb_grant_2: pure grant logic (inputs: valids, state, last_grant, force; outputs: grant0/grant1).
- FSM, counter, RAM mux and response pipeline stay in ram_port_arbiter.

Test Plan:
- Both valid reads, addr 0x010 / 0x020, RR mode: req0_ready cycle 1, req1_ready cycle 2; rsp0 pulses cycle 2 with mem[0x010]; rsp1 pulses cycle 3 with mem[0x020].
- Req1 write 0xBEEF @0x005 then req0 read @0x005 next cycle: rsp0_rdata=0xBEEF one cycle after the read is accepted.
- FIXED_PRIORITY=1, MAX_WAIT=3, req0 continuously valid, req1 valid: req1_ready asserted on the 4th cycle of waiting (wait_count reaches 3); wait_count then reads 0.
- Req0 lock=1 for 3 reads with a 2-cycle valid gap, req1 valid throughout: req1_ready stays 0 until req0 transfers with lock=0, then req1 is granted next cycle.
- READ_LATENCY=2, read accepted, reset asserted one cycle later: no rspN_valid after release; ram_enable=0 in reset.
- Req0 valid dropped before ready while OWN1: no RAM access issued for req0; ram_enable reflects req1 only.
